// File: rtl/frame_pkg.sv
// Shared frame-interface definitions: default widths, FSM state encoding and
// the packed beat layout used by frame2axi_stream and axi_stream2frame.
package frame_pkg;

    localparam int FRM_DATA_WIDTH  = 24;
    localparam int FRM_IMG_W_WIDTH = 11;

    typedef logic [0:0] frm_state_t;
    localparam frm_state_t WAIT_SOF = 1'b0;
    localparam frm_state_t IN_FRAME = 1'b1;

    typedef struct packed {
        logic [FRM_DATA_WIDTH-1:0] data;
        logic                      sof;
        logic                      eof;
        logic                      sol;
        logic                      eol;
    } frm_beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Generic 2-entry registered valid/ready buffer: an output register plus one
// skid register; s_ready_o is registered and drops only when the skid is full.
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             ready_q;
    logic             in_fire, out_fire;

    assign in_fire  = s_valid_i & ready_q;
    assign out_fire = out_valid_q & m_ready_i;

    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_fire) begin
            out_valid_d  = skid_valid_q;
            skid_valid_d = 1'b0;
            if (skid_valid_q) begin
                out_data_d = skid_data_q;
            end
        end
        // ready_q guarantees the skid is empty whenever a beat is accepted
        if (in_fire) begin
            if (!out_valid_q || out_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = s_data_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = s_data_i;
            end
        end
    end

    // NOTE: payload registers are reset as well, because the outputs must read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ~skid_valid_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;

endmodule

// File: rtl/frame2axi_stream.sv
// Frame interface (val/rdy + sof/eof/sol/eol) to AXI4-Stream video master.
// Optional line-length checking is built when FRAME2AXIS_LEN_CHECK_EN is defined.
module frame2axi_stream
    import frame_pkg::*;
#(
    parameter int DATA_WIDTH  = FRM_DATA_WIDTH,
    parameter int IMG_W_WIDTH = FRM_IMG_W_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IMG_W_WIDTH-1:0] cfg_img_w,
    input  logic                   s_frm_val,
    output logic                   s_frm_rdy,
    input  logic [DATA_WIDTH-1:0]  s_frm_data,
    input  logic                   s_frm_sof,
    input  logic                   s_frm_eof,
    input  logic                   s_frm_sol,
    input  logic                   s_frm_eol,
    output logic [DATA_WIDTH-1:0]  m_axi_stream_tdata,
    output logic                   m_axi_stream_tvalid,
    input  logic                   m_axi_stream_tready,
    output logic                   m_axi_stream_tuser,
    output logic                   m_axi_stream_tlast,
    output logic                   frm_done,
    input  logic                   err_clr,
    output logic                   err_line_len,
    output logic                   err_sof
);

    localparam int PAYLOAD_W = DATA_WIDTH + 3;

    logic                 beat_acc, beat_fwd, fwd_fire;
    logic                 force_last, len_err;
    logic [PAYLOAD_W-1:0] buf_din, buf_dout;
    logic                 out_eof;
    frm_state_t           state_q, state_d;
    logic                 err_sof_q, err_sof_d;
    logic                 unused_inputs;

    assign beat_acc = s_frm_val & s_frm_rdy;
    assign beat_fwd = (state_q == IN_FRAME) | s_frm_sof;
    assign fwd_fire = beat_acc & beat_fwd;

    // Payload carries the beat's eof separately so a forced tlast never fakes frm_done
    assign buf_din = {s_frm_eof, s_frm_sof, s_frm_eol | s_frm_eof | force_last, s_frm_data};

    axis_skid_buf #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (s_frm_val & beat_fwd),
        .s_ready_o (s_frm_rdy),
        .s_data_i  (buf_din),
        .m_valid_o (m_axi_stream_tvalid),
        .m_ready_i (m_axi_stream_tready),
        .m_data_o  (buf_dout)
    );

    assign {out_eof, m_axi_stream_tuser, m_axi_stream_tlast, m_axi_stream_tdata} = buf_dout;
    assign frm_done = m_axi_stream_tvalid & m_axi_stream_tready & out_eof;

    always_comb begin
        state_d   = state_q;
        err_sof_d = err_sof_q & ~err_clr;
        if (fwd_fire) begin
            state_d = s_frm_eof ? WAIT_SOF : IN_FRAME;
        end
        if (beat_acc && s_frm_sof && state_q == IN_FRAME) begin
            err_sof_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_SOF;
            err_sof_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_sof_q <= err_sof_d;
        end
    end

    assign err_sof = err_sof_q;

`ifdef FRAME2AXIS_LEN_CHECK_EN
    localparam logic [IMG_W_WIDTH-1:0] ONE = {{(IMG_W_WIDTH-1){1'b0}}, 1'b1};

    logic [IMG_W_WIDTH-1:0] img_w_q, img_w_d;
    logic [IMG_W_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [IMG_W_WIDTH-1:0] eff_w, eff_idx;
    logic                   len_on, at_last;
    logic                   err_len_q, err_len_d;

    // A sof beat is pixel 0 of a fresh line measured against the freshly sampled width
    assign eff_w      = s_frm_sof ? cfg_img_w : img_w_q;
    assign eff_idx    = s_frm_sof ? '0 : pix_cnt_q;
    assign len_on     = (eff_w != '0);
    assign at_last    = len_on && (eff_idx == eff_w - ONE);
    assign force_last = at_last & ~s_frm_eol;
    assign len_err    = fwd_fire & len_on & (s_frm_eol ^ at_last);

    always_comb begin
        img_w_d   = img_w_q;
        pix_cnt_d = pix_cnt_q;
        err_len_d = len_err | (err_len_q & ~err_clr);
        if (fwd_fire) begin
            pix_cnt_d = (s_frm_eol | s_frm_eof | force_last) ? '0 : eff_idx + ONE;
            if (s_frm_sof) begin
                img_w_d = cfg_img_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            img_w_q   <= '0;
            pix_cnt_q <= '0;
            err_len_q <= 1'b0;
        end else begin
            img_w_q   <= img_w_d;
            pix_cnt_q <= pix_cnt_d;
            err_len_q <= err_len_d;
        end
    end

    assign err_line_len  = err_len_q;
    assign unused_inputs = s_frm_sol;
`else
    assign force_last    = 1'b0;
    assign len_err       = 1'b0;
    assign err_line_len  = 1'b0;
    assign unused_inputs = ^{cfg_img_w, s_frm_sol, len_err};
`endif

endmodule

// File: tb/tb_frame2axi_stream.sv
// Self-checking bench for frame2axi_stream: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_frame2axi_stream;
    import frame_pkg::*;

`ifdef FRAME2AXIS_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] cfg_img_w = 11'd4;
    logic        s_frm_val = 1'b0;
    logic        s_frm_rdy;
    logic [23:0] s_frm_data = '0;
    logic        s_frm_sof = 1'b0, s_frm_eof = 1'b0, s_frm_sol = 1'b0, s_frm_eol = 1'b0;
    logic [23:0] tdata;
    logic        tvalid, tuser, tlast;
    logic        tready = 1'b0;
    logic        frm_done;
    logic        err_clr = 1'b0;
    logic        err_line_len, err_sof;

    frame2axi_stream dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_img_w           (cfg_img_w),
        .s_frm_val           (s_frm_val),
        .s_frm_rdy           (s_frm_rdy),
        .s_frm_data          (s_frm_data),
        .s_frm_sof           (s_frm_sof),
        .s_frm_eof           (s_frm_eof),
        .s_frm_sol           (s_frm_sol),
        .s_frm_eol           (s_frm_eol),
        .m_axi_stream_tdata  (tdata),
        .m_axi_stream_tvalid (tvalid),
        .m_axi_stream_tready (tready),
        .m_axi_stream_tuser  (tuser),
        .m_axi_stream_tlast  (tlast),
        .frm_done            (frm_done),
        .err_clr             (err_clr),
        .err_line_len        (err_line_len),
        .err_sof             (err_sof)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Downstream ready: 0 = always, 1 = 1,0,0,1,0,1 pattern, 2 = random, 3 = stalled
    int rdy_mode = 0;
    int rdy_cyc  = 0;
    bit pat[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tready = 1'b1;
            1:       tready = pat[rdy_cyc % 6];
            2:       tready = 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
        rdy_cyc++;
    end

    // Reference model: beats accepted but not yet transferred, in order
    typedef struct {
        logic [23:0] data;
        logic        tuser;
        logic        tlast;
        logic        eof;
    } exp_t;

    exp_t q[$];
    exp_t lg[$];
    bit   model_live = 1'b0;
    bit   rst_last   = 1'b0;
    bit   m_in_frame = 1'b0;
    int   m_img_w    = 0;
    int   m_pix      = 0;
    bit   m_err_sof  = 1'b0;
    bit   m_err_len  = 1'b0;
    int   done_cnt   = 0;

    always @(negedge clk) begin
        exp_t e;
        bit   set_sof, set_len, at_last;
        if (model_live) begin
            check("tvalid", tvalid, q.size() != 0);
            check("s_frm_rdy", s_frm_rdy, !rst_last && q.size() < 2);
            check("err_sof", err_sof, m_err_sof);
            check("err_line_len", err_line_len, m_err_len);
            if (q.size() != 0)
                check("beat", {tdata, tuser, tlast}, {q[0].data, q[0].tuser, q[0].tlast});
            check("frm_done", frm_done, q.size() != 0 && tready && q[0].eof);
        end
        if (frm_done) done_cnt++;
        if (rst) begin
            q.delete();
            model_live = 1'b1;
            rst_last   = 1'b1;
            m_in_frame = 1'b0;
            m_img_w    = 0;
            m_pix      = 0;
            m_err_sof  = 1'b0;
            m_err_len  = 1'b0;
        end else if (model_live) begin
            rst_last = 1'b0;
            set_sof  = 1'b0;
            set_len  = 1'b0;
            if (q.size() != 0 && tready) begin
                lg.push_back(q[0]);
                void'(q.pop_front());
            end
            if (s_frm_val && s_frm_rdy) begin
                if (m_in_frame && s_frm_sof) set_sof = 1'b1;
                if (m_in_frame || s_frm_sof) begin
                    if (s_frm_sof) begin
                        m_img_w = int'(cfg_img_w);
                        m_pix   = 0;
                    end
                    e.data  = s_frm_data;
                    e.tuser = s_frm_sof;
                    e.eof   = s_frm_eof;
                    e.tlast = s_frm_eol | s_frm_eof;
                    if (LEN_EN && m_img_w != 0) begin
                        at_last = (m_pix == m_img_w - 1);
                        if (at_last != s_frm_eol) set_len = 1'b1;
                        if (at_last) e.tlast = 1'b1;
                    end
                    q.push_back(e);
                    m_pix      = e.tlast ? 0 : (m_pix + 1) % 2048;
                    m_in_frame = !s_frm_eof;
                end
            end
            m_err_sof = set_sof | (m_err_sof & !err_clr);
            m_err_len = set_len | (m_err_len & !err_clr);
        end
    end

    // Present one beat and hold it until accepted; returns 1 ns after the accepting edge
    task automatic send(input frm_beat_t b);
        int budget;
        budget     = 0;
        s_frm_val  = 1'b1;
        s_frm_data = b.data;
        s_frm_sof  = b.sof;
        s_frm_eof  = b.eof;
        s_frm_sol  = b.sol;
        s_frm_eol  = b.eol;
        forever begin
            @(negedge clk);
            if (s_frm_rdy) break;
            budget++;
            if (budget > 200) begin
                check("send_timeout", budget, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_frm_val = 1'b0;
    endtask

    task automatic send_px(input int d, input bit sof, input bit eof, input bit sol, input bit eol);
        frm_beat_t b;
        b.data = 24'(d);
        b.sof  = sof;
        b.eof  = eof;
        b.sol  = sol;
        b.eol  = eol;
        send(b);
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !tvalid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic frame_4x2();
        for (int i = 0; i < 8; i++)
            send_px(i, i == 0, i == 7, (i % 4) == 0, (i % 4) == 3);
    endtask

    initial begin
        int tu_cnt, tl_cnt, w, h, gap;
        bit ok_seq;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 4x2 frame, tready held high
        cfg_img_w = 11'd4;
        lg.delete();
        done_cnt = 0;
        send_px(0, 1, 0, 1, 0);
        check("first_latency_tvalid", tvalid, 1'b1);
        for (int i = 1; i < 8; i++)
            send_px(i, 0, i == 7, (i % 4) == 0, (i % 4) == 3);
        drain();
        tu_cnt = 0;
        tl_cnt = 0;
        foreach (lg[i]) begin
            tu_cnt += int'(lg[i].tuser);
            tl_cnt += int'(lg[i].tlast);
        end
        check("t1_beats", lg.size(), 8);
        check("t1_tuser0", lg[0].tuser, 1'b1);
        check("t1_tuser_cnt", tu_cnt, 1);
        check("t1_tlast3", lg[3].tlast, 1'b1);
        check("t1_tlast7", lg[7].tlast, 1'b1);
        check("t1_tlast_cnt", tl_cnt, 2);
        check("t1_frm_done", done_cnt, 1);
        check("t1_errs", {err_sof, err_line_len}, 2'b00);

        // Same frame with tready toggling 1,0,0,1,0,1
        rdy_mode = 1;
        lg.delete();
        frame_4x2();
        drain();
        rdy_mode = 0;
        ok_seq = (lg.size() == 8);
        foreach (lg[i]) if (lg[i].data != 24'(i)) ok_seq = 1'b0;
        check("t2_seq_intact", ok_seq, 1'b1);

        // Pre-frame garbage then a 4x1 frame
        lg.delete();
        for (int i = 0; i < 3; i++) send_px(100 + i, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) send_px(i, i == 0, i == 3, i == 0, i == 3);
        drain();
        check("t3_beats", lg.size(), 4);
        check("t3_first", {lg[0].tuser, lg[0].data}, {1'b1, 24'd0});

        // sof re-issued mid-line, then clear; then set-vs-clear collision
        lg.delete();
        send_px(0, 1, 0, 1, 0);
        send_px(1, 0, 0, 0, 0);
        send_px(50, 1, 0, 1, 0);
        for (int i = 51; i < 54; i++) send_px(i, 0, i == 53, 0, i == 53);
        drain();
        check("t4_err_sof", err_sof, 1'b1);
        check("t4_resync", {lg[2].tuser, lg[2].data}, {1'b1, 24'd50});
        check("t4_beats", lg.size(), 6);
        pulse_clr();
        check("t4_err_clr", err_sof, 1'b0);
        send_px(60, 1, 0, 1, 0);
        err_clr = 1'b1;
        send_px(61, 1, 1, 1, 1);
        err_clr = 1'b0;
        drain();
        check("t4_set_wins", err_sof, 1'b1);
        pulse_clr();

        // Line-length checking (expectations depend on the build)
        cfg_img_w = 11'd4;
        send_px(0, 1, 0, 1, 0);
        send_px(1, 0, 0, 0, 0);
        send_px(2, 0, 0, 0, 1);
        drain();
        check("t5_short_line", err_line_len, LEN_EN);
        pulse_clr();
        lg.delete();
        for (int i = 0; i < 5; i++) send_px(10 + i, 0, 0, i == 0, 0);
        send_px(15, 0, 1, 0, 1);
        drain();
        check("t5_forced_tlast", lg[3].tlast, LEN_EN);
        check("t5_no_early_tlast", {lg[2].tlast, lg[4].tlast}, 2'b00);
        check("t5_long_line", err_line_len, LEN_EN);
        pulse_clr();

        // Random frames, garbage, spurious sof, bad eol, random gaps and tready
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            cfg_img_w = 11'($urandom_range(0, 5));
            w = $urandom_range(1, 5);
            h = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) send_px($urandom, 0, $urandom_range(0, 1), 1, 1);
            for (int y = 0; y < h; y++) begin
                for (int x = 0; x < w; x++) begin
                    err_clr = ($urandom_range(0, 7) == 0);
                    send_px($urandom,
                            (x == 0 && y == 0) || ($urandom_range(0, 19) == 0),
                            (x == w - 1 && y == h - 1),
                            x == 0,
                            (x == w - 1) ^ ($urandom_range(0, 9) == 0));
                    err_clr = 1'b0;
                    gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        end
        rdy_mode = 0;
        drain();

        // Reset with both buffer entries full
        rdy_mode = 3;
        @(posedge clk);
        #1;
        send_px(7, 1, 0, 1, 0);
        send_px(8, 0, 0, 0, 0);
        check("t7_full_tvalid", tvalid, 1'b1);
        check("t7_full_rdy", s_frm_rdy, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t7_rst_tvalid", tvalid, 1'b0);
        check("t7_rst_rdy", s_frm_rdy, 1'b0);
        check("t7_rst_outs", {tdata, tuser, tlast, frm_done}, 27'd0);
        rst = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        check("t7_post_rdy", s_frm_rdy, 1'b1);
        send_px(9, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t7_wait_sof_discard", tvalid, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
